// File: rtl/button_event_arbiter_pkg.sv
// Shared types and helpers for the button event arbiter.
// Holds FSM states, parameter defaults and id width math.
package button_pkg;

  localparam int N_BTN_DEF = 4;
  localparam int GAP_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    GAP
  } state_t;

  function automatic int idw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Event offer handshake between the arbiter and its consumer.
// Master drives valid/id, slave drives ready.
interface button_event_arbiter_if #(
  parameter int IDW = 2
) ();

  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_ready;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );

endinterface

// File: rtl/button_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request
// at or after ptr, wrapping from the top index to 0.
module rr_pick
  import button_pkg::*;
#(
  parameter  int N_BTN = N_BTN_DEF,
  localparam int IDW   = idw_f(N_BTN)
) (
  input  logic [N_BTN-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             found,
  output logic [IDW-1:0]   idx
);

  int j;

  // Scan downward so the nearest candidate is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_BTN) j = j - N_BTN;
      if (req[IDW'(j)]) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Button edge detector with pending flags, round-robin
// event offer and an enforced idle gap after each accept.
module button_event_arbiter
  import button_pkg::*;
#(
  parameter  int N_BTN      = N_BTN_DEF,
  parameter  int GAP_CYCLES = GAP_DEF,
  localparam int IDW        = idw_f(N_BTN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_BTN-1:0]      btn_in,
  output logic [N_BTN-1:0]      pending,
  output logic                  overrun,
  button_event_arbiter_if.master evt
);

  state_t           state_q, state_d;
  logic [N_BTN-1:0] prev_q;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             ovr_q, ovr_d;

  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] clr;
  logic             found;
  logic [IDW-1:0]   pick;

  assign rise = btn_in & ~prev_q;

  rr_pick #(
    .N_BTN (N_BTN)
  ) u_pick (
    .req   (pend_q),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      pend_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= btn_in;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    id_d    = id_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          clr     = {{(N_BTN-1){1'b0}}, 1'b1} << pick;
          id_d    = pick;
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (evt.evt_ready) begin
          valid_d = 1'b0;
          ptr_d   = (id_q == IDW'(N_BTN - 1)) ?
                    '0 : id_q + IDW'(1);
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = 8'(GAP_CYCLES);
          end
        end
      end
      GAP: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A fresh rise beats a same-cycle grant clear.
    pend_d = (pend_q & ~clr) | rise;
    ovr_d  = |(rise & pend_q & ~clr);
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_id    = id_q;
  assign pending       = pend_q;
  assign overrun       = ovr_q;

endmodule
